// File: rtl/airi5c_uart_rx.sv
// UART receiver: 2-FF synchronised rxd, bit-centre sampling of 5-8 data bits with optional parity and 1/2 stop bits.
// Completion pulses (push or exactly one error) are registered and appear one cycle after the last stop-bit sample.
module airi5c_uart_rx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity,
    input  logic                 stop_bits,
    input  logic                 rxd,
    input  logic                 fifo_full,
    output logic                 push,
    output logic [7:0]           data_out,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overflow_error,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rxd_m, rxd_s, rxd_prev;
    logic [DIV_WIDTH-1:0] cnt, div_l, div_eff;
    logic [2:0]           nbits_l, bit_cnt;
    logic                 par_en_l, par_odd_l, two_stop_l;
    logic [7:0]           shreg, aligned;
    logic                 par_acc, par_err, frm_err, frm_now;
    logic                 fall, expire, samp;
    logic                 load_half, load_full, finish;

    assign div_eff = (clk_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clk_div;
    assign fall    = rxd_prev & ~rxd_s;
    assign expire  = (cnt == '0);
    assign samp    = expire & rx_en;
    // nbits_l holds N-1, so 7-nbits_l is the number of unused MSBs to shift away.
    assign aligned = shreg >> (3'd7 - nbits_l);
    assign frm_now = frm_err | ~rxd_s;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_half = 1'b0;
        load_full = 1'b0;
        finish    = 1'b0;
        if (!rx_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (fall) begin
                    state_nxt = START;
                    load_half = 1'b1;
                end
                START: if (expire) begin
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        load_full = 1'b1;
                    end
                end
                DATA: if (expire) begin
                    load_full = 1'b1;
                    if (bit_cnt == nbits_l) state_nxt = par_en_l ? PARITY : STOP;
                end
                PARITY: if (expire) begin
                    load_full = 1'b1;
                    state_nxt = STOP;
                end
                STOP: if (expire) begin
                    if (two_stop_l && bit_cnt == 3'd0) begin
                        load_full = 1'b1;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_m          <= 1'b1;
            rxd_s          <= 1'b1;
            rxd_prev       <= 1'b1;
            cnt            <= '0;
            div_l          <= '0;
            nbits_l        <= '0;
            bit_cnt        <= '0;
            par_en_l       <= 1'b0;
            par_odd_l      <= 1'b0;
            two_stop_l     <= 1'b0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            par_err        <= 1'b0;
            frm_err        <= 1'b0;
            push           <= 1'b0;
            data_out       <= '0;
            frame_error    <= 1'b0;
            parity_error   <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            rxd_m          <= rxd;
            rxd_s          <= rxd_m;
            rxd_prev       <= rxd_s;
            push           <= 1'b0;
            frame_error    <= 1'b0;
            parity_error   <= 1'b0;
            overflow_error <= 1'b0;

            // Frame format is captured at the start edge and held for the whole frame.
            if (load_half) begin
                cnt        <= (div_eff >> 1) - DIV_WIDTH'(1);
                div_l      <= div_eff;
                nbits_l    <= {1'b1, data_bits};
                par_en_l   <= parity[0] ^ parity[1];
                par_odd_l  <= parity[1];
                two_stop_l <= stop_bits;
            end else if (load_full) begin
                cnt <= div_l - DIV_WIDTH'(1);
            end else if (!expire) begin
                cnt <= cnt - DIV_WIDTH'(1);
            end

            if (samp) begin
                case (state)
                    START: begin
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                    DATA: begin
                        shreg   <= {rxd_s, shreg[7:1]};
                        par_acc <= par_acc ^ rxd_s;
                        bit_cnt <= (state_nxt == DATA) ? bit_cnt + 3'd1 : 3'd0;
                    end
                    PARITY: par_err <= par_odd_l ? ~(par_acc ^ rxd_s) : (par_acc ^ rxd_s);
                    STOP: begin
                        frm_err <= frm_now;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    default: ;
                endcase
            end

            if (finish) begin
                data_out <= aligned;
                if (frm_now)        frame_error    <= 1'b1;
                else if (par_err)   parity_error   <= 1'b1;
                else if (fifo_full) overflow_error <= 1'b1;
                else                push           <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_airi5c_uart_rx.sv
// Bench for airi5c_uart_rx: frames built from their serial description, expected outcome queued, monitor compares pulses.
module tb_airi5c_uart_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, rx_en, stop_bits, rxd, fifo_full;
    logic [W-1:0] clk_div;
    logic [1:0]   data_bits, parity;
    logic         push, frame_error, parity_error, overflow_error, busy;
    logic [7:0]   data_out;

    typedef struct packed {
        logic [1:0] kind;   // 0 push, 1 frame, 2 parity, 3 overflow
        logic [7:0] dat;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    airi5c_uart_rx #(.DIV_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .clk_div(clk_div),
        .data_bits(data_bits), .parity(parity), .stop_bits(stop_bits),
        .rxd(rxd), .fifo_full(fifo_full), .push(push), .data_out(data_out),
        .frame_error(frame_error), .parity_error(parity_error),
        .overflow_error(overflow_error), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (push | frame_error | parity_error | overflow_error) begin
            logic [1:0] got;
            ev_t e;
            got = push ? 2'd0 : frame_error ? 2'd1 : parity_error ? 2'd2 : 2'd3;
            vectors++;
            if ($countones({push, frame_error, parity_error, overflow_error}) != 1) begin
                miscompares++;
                $display("FAIL multi_pulse: got %b expected one-hot",
                         {push, frame_error, parity_error, overflow_error});
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got kind %0d data %h expected none", got, data_out);
            end else begin
                e = exp_q.pop_front();
                if (got != e.kind || (got == 2'd0 && data_out != e.dat)) begin
                    miscompares++;
                    $display("FAIL event: got kind %0d data %h expected kind %0d data %h",
                             got, data_out, e.kind, e.dat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialises one frame using the current config; stop_zero marks stop bits sent as 0.
    task automatic send_frame(input logic [7:0] byte_in, input bit par_flip,
                              input logic [1:0] stop_zero, input int trail_low);
        int         eff, nb, ns, n, mask;
        logic [11:0] lv;
        logic [7:0] d;
        logic       pbit;
        bit         pen, ferr;
        ev_t        e;
        eff  = (clk_div < 4) ? 4 : int'(clk_div);
        nb   = 5 + int'(data_bits);
        mask = (1 << nb) - 1;
        d    = byte_in & mask[7:0];
        pen  = (parity == 2'b01) || (parity == 2'b10);
        pbit = (parity == 2'b01) ? ^d : ~^d;
        if (par_flip) pbit = ~pbit;
        ns   = stop_bits ? 2 : 1;
        lv   = '0;
        n    = 0;
        lv[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin lv[n] = d[i]; n++; end
        if (pen) begin lv[n] = pbit; n++; end
        ferr = 0;
        for (int s = 0; s < ns; s++) begin
            lv[n] = ~stop_zero[s];
            if (stop_zero[s]) ferr = 1;
            n++;
        end
        e.dat = d;
        if (ferr)                  e.kind = 2'd1;
        else if (pen && par_flip)  e.kind = 2'd2;
        else if (fifo_full)        e.kind = 2'd3;
        else                       e.kind = 2'd0;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            rxd = lv[i];
            cycles(eff);
        end
        if (trail_low > 0) begin
            rxd = 1'b0;
            cycles(trail_low);
        end
        rxd = 1'b1;
        cycles(2 * eff + 4);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_push"}, {31'd0, push}, 32'd0);
        check({name, "_data"}, {24'd0, data_out}, 32'd0);
        check({name, "_ferr"}, {31'd0, frame_error}, 32'd0);
        check({name, "_perr"}, {31'd0, parity_error}, 32'd0);
        check({name, "_oerr"}, {31'd0, overflow_error}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; rx_en = 1'b1; rxd = 1'b1; fifo_full = 1'b0;
        clk_div = 16; data_bits = 2'b11; parity = 2'b00; stop_bits = 1'b0;
        cycles(4);
        check_quiet("reset");
        reset = 1'b0;
        cycles(4);

        send_frame(8'hA5, 0, 2'b00, 0);

        data_bits = 2'b10; parity = 2'b01; stop_bits = 1'b1;
        send_frame(8'h41, 1, 2'b00, 0);

        data_bits = 2'b11; parity = 2'b00; stop_bits = 1'b0;
        send_frame(8'h00, 0, 2'b01, 3 * 16);
        send_frame(8'h3C, 0, 2'b00, 0);

        rxd = 1'b0; cycles(5);
        rxd = 1'b1; cycles(48);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        fifo_full = 1'b1;
        send_frame(8'h55, 0, 2'b00, 0);
        fifo_full = 1'b0;
        send_frame(8'h55, 0, 2'b00, 0);

        // 0x81 LSB first: start 0, then 1,0,0 before reset hits mid-DATA.
        rxd = 1'b0; cycles(16);
        rxd = 1'b1; cycles(16);
        rxd = 1'b0; cycles(32);
        reset = 1'b1; rxd = 1'b1;
        cycles(2);
        check_quiet("midreset");
        reset = 1'b0;
        cycles(40);
        send_frame(8'h7E, 0, 2'b00, 0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] sz;
            clk_div   = W'($urandom_range(2, 20));
            data_bits = 2'($urandom_range(0, 3));
            parity    = 2'($urandom_range(0, 3));
            stop_bits = 1'($urandom_range(0, 1));
            fifo_full = ($urandom_range(0, 3) == 0);
            sz        = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(8'($urandom), ($urandom_range(0, 2) == 0), sz, 0);
        end
        fifo_full = 1'b0;

        cycles(50);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
